// File: rtl/komut_uretici.sv
`default_nettype none
// ============================================================================
// Module   : komut_uretici
// Brief    : Debounces the forward/turn buttons and issues step pulses and
//            turn toggles to bit_kosusu. OTOMATIK_TEKRAR_EN enables forward
//            auto-repeat while the button is held.
// Revision : 1.0 - initial release
// ============================================================================
module komut_uretici #(
    parameter int SUZGEC      = 16,
    parameter int TEKRAR_SURE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ileri,
    input  logic       btn_don,
    input  logic       bitti_mi,
    output logic       ileri,
    output logic       don,
    output logic [7:0] basis_say
);

    localparam logic [1:0] c_bos     = 2'd0;
    localparam logic [1:0] c_basili  = 2'd1;
    localparam logic [1:0] c_kilitli = 2'd2;
`ifdef OTOMATIK_TEKRAR_EN
    localparam logic [1:0] c_tekrar  = 2'd3;
    localparam logic [7:0] c_tekrar_son = 8'(TEKRAR_SURE - 1);
`endif
    localparam logic [7:0] c_suzgec_son = 8'(SUZGEC - 1);

    if (SUZGEC < 1 || SUZGEC > 255 || TEKRAR_SURE < 2 || TEKRAR_SURE > 255) begin : g_param_hata
        $error("komut_uretici: SUZGEC or TEKRAR_SURE out of range");
    end

    logic [1:0] w_ham;
    logic [1:0] w_deb;

    assign w_ham = {btn_don, btn_ileri};

    // Bit 0 is the forward button, bit 1 the turn button.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dugme
        logic       r_sync1;
        logic       r_sync2;
        logic       r_deb;
        logic [7:0] r_sayac;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_sayac <= 8'd0;
            end else begin
                r_sync1 <= w_ham[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_deb) begin
                    r_sayac <= 8'd0;
                end else if (r_sayac == c_suzgec_son) begin
                    r_deb   <= r_sync2;
                    r_sayac <= 8'd0;
                end else begin
                    r_sayac <= r_sayac + 8'd1;
                end
            end
        end

        assign w_deb[gi] = r_deb;
    end

    logic [1:0] r_durum_ileri;
    logic [1:0] r_durum_don;
    logic       w_ileri_ates;
    logic       w_don_ates;
`ifdef OTOMATIK_TEKRAR_EN
    logic [7:0] r_tekrar_sayac;
`endif

    always_comb begin
        w_ileri_ates = 1'b0;
        if (w_deb[0] && !bitti_mi) begin
            if (r_durum_ileri == c_bos) begin
                w_ileri_ates = 1'b1;
            end
`ifdef OTOMATIK_TEKRAR_EN
            else if ((r_durum_ileri == c_basili || r_durum_ileri == c_tekrar) &&
                     r_tekrar_sayac == c_tekrar_son) begin
                w_ileri_ates = 1'b1;
            end
`endif
        end
    end

    assign w_don_ates = w_deb[1] && !bitti_mi && (r_durum_don == c_bos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_durum_ileri <= c_bos;
`ifdef OTOMATIK_TEKRAR_EN
            r_tekrar_sayac <= 8'd0;
`endif
        end else begin
            case (r_durum_ileri)
                c_bos: begin
                    if (w_deb[0]) begin
                        r_durum_ileri <= bitti_mi ? c_kilitli : c_basili;
                    end
                end
                c_kilitli: begin
                    if (!w_deb[0]) begin
                        r_durum_ileri <= c_bos;
                    end
                end
`ifdef OTOMATIK_TEKRAR_EN
                c_basili, c_tekrar: begin
                    if (!w_deb[0]) begin
                        r_durum_ileri <= c_bos;
                    end else if (bitti_mi) begin
                        r_durum_ileri <= c_kilitli;
                    end else if (w_ileri_ates) begin
                        r_durum_ileri <= c_tekrar;
                    end
                end
`else
                c_basili: begin
                    if (!w_deb[0]) begin
                        r_durum_ileri <= c_bos;
                    end else if (bitti_mi) begin
                        r_durum_ileri <= c_kilitli;
                    end
                end
`endif
                default: r_durum_ileri <= c_bos;
            endcase
`ifdef OTOMATIK_TEKRAR_EN
            // Restarts on every issued pulse, so the period runs from the last step.
            if (w_ileri_ates || (r_durum_ileri != c_basili && r_durum_ileri != c_tekrar)) begin
                r_tekrar_sayac <= 8'd0;
            end else begin
                r_tekrar_sayac <= r_tekrar_sayac + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_durum_don <= c_bos;
        end else begin
            case (r_durum_don)
                c_bos: begin
                    if (w_deb[1]) begin
                        r_durum_don <= bitti_mi ? c_kilitli : c_basili;
                    end
                end
                c_basili: begin
                    if (!w_deb[1]) begin
                        r_durum_don <= c_bos;
                    end else if (bitti_mi) begin
                        r_durum_don <= c_kilitli;
                    end
                end
                c_kilitli: begin
                    if (!w_deb[1]) begin
                        r_durum_don <= c_bos;
                    end
                end
                default: r_durum_don <= c_bos;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ileri     <= 1'b0;
            don       <= 1'b1;
            basis_say <= 8'd0;
        end else begin
            ileri <= w_ileri_ates;
            if (w_don_ates) begin
                don <= ~don;
            end
            if (w_ileri_ates && basis_say != 8'hFF) begin
                basis_say <= basis_say + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/komut_uretici.md
KOMUT_URETICI -- requirements
Module: komut_uretici

Interface
REQ-001 Parameter SUZGEC, default 16: debounce length in clk cycles, range 1..255.
REQ-002 Parameter TEKRAR_SURE, default 32: auto-repeat period in clk cycles, range 2..255; used only with OTOMATIK_TEKRAR_EN.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_ileri  input  1  raw, asynchronous, bouncing "forward" push-button; high = pressed.
REQ-006 btn_don  input  1  raw, asynchronous, bouncing "turn" push-button; high = pressed.
REQ-007 bitti_mi  input  1  game-finished flag from the downstream bit_kosusu; high = finished.
REQ-008 ileri  output  1  registered one-cycle "step forward" pulse to bit_kosusu.
REQ-009 don  output  1  registered turn-direction level to bit_kosusu.
REQ-010 basis_say  output  8  registered count of ileri pulses issued.

Function
REQ-011 Each button SHALL pass through its own two-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debounce counter; the debounced level SHALL change only after the synchronized input differs from it for SUZGEC consecutive cycles; any sample equal to the debounced level SHALL clear the counter.
REQ-013 Per-button FSM states: BOS (released), BASILI (held), KILITLI (held but blocked); TEKRAR (auto-repeat) exists only with OTOMATIK_TEKRAR_EN.
REQ-014 BOS -> BASILI on a debounced rising edge while bitti_mi=0; BOS -> KILITLI on a debounced rising edge while bitti_mi=1.
REQ-015 BASILI/TEKRAR/KILITLI -> BOS on a debounced falling edge; no other exit from KILITLI.
REQ-016 Entering BASILI on btn_ileri SHALL drive ileri=1 for exactly one cycle.
REQ-017 Latency: raw btn_ileri rising before clk edge E and held clean SHALL produce ileri=1 in the cycle after edge E+SUZGEC+2 (2 sync + SUZGEC debounce + 1 output register).
REQ-018 Entering BASILI on btn_don SHALL toggle don in the cycle with the same latency as REQ-017.
REQ-019 While bitti_mi=1, ileri SHALL be 0 and don SHALL hold; a button in BASILI or TEKRAR at the rising edge of bitti_mi SHALL move to KILITLI, so no command issues until release and a new press.
REQ-020 Pulses shorter than SUZGEC cycles (after synchronization) SHALL produce no state change and no output.
REQ-021 Simultaneous qualifying events on both buttons in one cycle SHALL both take effect in that cycle.
REQ-022 basis_say SHALL increment by 1 on each cycle with ileri=1 and saturate at 255 (no wrap).

Reset
REQ-023 rst=1 SHALL immediately force: ileri=0, don=1, basis_say=0, both FSMs to BOS, debounce counters and debounced levels to 0, synchronizer flops to 0.
REQ-024 After rst falls, a button held throughout reset SHALL be treated as a new press (one ileri pulse after the REQ-017 latency); reset asserted mid-debounce or mid-repeat SHALL discard the pending event.

Configuration
REQ-025 Macro OTOMATIK_TEKRAR_EN: when defined, BASILI on btn_ileri SHALL go to TEKRAR after TEKRAR_SURE cycles held, and TEKRAR SHALL issue one ileri pulse every TEKRAR_SURE cycles while held and bitti_mi=0; btn_don never auto-repeats.
REQ-026 When OTOMATIK_TEKRAR_EN is undefined, the TEKRAR state and its counter SHALL be absent and each press SHALL yield exactly one ileri pulse.

Verification (SUZGEC=4, TEKRAR_SURE=8)
REQ-027 rst pulse then btn_ileri=1 held 40 cycles -> exactly one ileri pulse 7 cycles after press (macro off), basis_say=1, don=1.
REQ-028 btn_ileri toggled every cycle for 20 cycles, then 0 -> no ileri pulse, basis_say=0.
REQ-029 btn_don pressed 3 times (10 cycles high, 10 low each) -> don 1->0->1->0, ileri never high.
REQ-030 btn_ileri held, bitti_mi=1 before its debounce completes, bitti_mi=0 after 20 cycles, still held -> no pulse; release and re-press -> one pulse.
REQ-031 Macro on, btn_ileri held 40 cycles -> pulses at cycles 7, 15, 23, 31, 39 after press, basis_say=5; 300 such pulses -> basis_say=255.
